// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RISC-V core.
// Sequences ALU, unified memory, IR and register file per instruction.
module rv_multicycle_ctrl #(
    parameter bit TRAP_ILLEGAL = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       imm_src,
    output logic             reg_write,
    output logic             instr_done,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       pc_update;
    logic       branch;
    logic       done_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic [2:0] funct_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // subtract only for R-type (op[5]) with funct7b5 set
    always_comb begin
        funct_alu = 3'b000;
        case (funct3)
            3'b000:  funct_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  funct_alu = 3'b101;
            3'b110:  funct_alu = 3'b011;
            3'b111:  funct_alu = 3'b010;
            default: funct_alu = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        done_raw      = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_control   = 3'b000;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_update    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d  = TRAP_ILLEGAL ? S_HALT : S_FETCH;
                        done_raw = !TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = funct_alu;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                branch      = 1'b1;
                done_raw    = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                illegal = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // every strobe is held low while rst is asserted
    assign pc_write   = !rst & (pc_update | (branch & zero));
    assign mem_write  = !rst & mem_write_raw;
    assign ir_write   = !rst & ir_write_raw;
    assign reg_write  = !rst & reg_write_raw;
    assign instr_done = !rst & done_raw;

    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, done_raw};
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-cycle vector table plus reset,
// trap and abort sequences.
module tb_rv_multicycle_ctrl;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;

    logic        pc_write, adr_src, mem_write, ir_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic        reg_write, instr_done, illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    logic        pc_write2, adr_src2, mem_write2, ir_write2;
    logic [1:0]  result_src2, alu_src_a2, alu_src_b2, imm_src2;
    logic [2:0]  alu_control2;
    logic        reg_write2, instr_done2, illegal2;
    logic [3:0]  state2;
    logic [31:0] instret2;

    rv_multicycle_ctrl #(.TRAP_ILLEGAL(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .reg_write(reg_write),
        .instr_done(instr_done), .illegal(illegal),
        .state(state), .instret(instret)
    );

    rv_multicycle_ctrl #(.TRAP_ILLEGAL(1'b0), .CNT_W(32)) dut_nop (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write2), .adr_src(adr_src2),
        .mem_write(mem_write2), .ir_write(ir_write2),
        .result_src(result_src2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_control(alu_control2),
        .imm_src(imm_src2), .reg_write(reg_write2),
        .instr_done(instr_done2), .illegal(illegal2),
        .state(state2), .instret(instret2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [3:0]  st;
        logic [17:0] outs;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] outs;
        logic [31:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [17:0] act_outs;
    assign act_outs = {pc_write, adr_src, mem_write, ir_write,
                       result_src, alu_src_a, alu_src_b,
                       alu_control, imm_src, reg_write,
                       instr_done, illegal};

    function automatic logic [17:0] pk(
        int pcw, int adr, int mw, int irw, int rs, int a, int b,
        int alu, int imm, int rw, int done, int ill);
        logic [17:0] r;
        r = {pcw[0], adr[0], mw[0], irw[0], rs[1:0], a[1:0], b[1:0],
             alu[2:0], imm[1:0], rw[0], done[0], ill[0]};
        return r;
    endfunction

    function automatic logic [17:0] f_row(int imm);
        return pk(1, 0, 0, 1, 2, 0, 2, 0, imm, 0, 0, 0);
    endfunction

    function automatic logic [17:0] d_row(int imm);
        return pk(0, 0, 0, 0, 0, 1, 1, 0, imm, 0, 0, 0);
    endfunction

    function automatic logic [17:0] wb_row(int imm);
        return pk(0, 0, 0, 0, 0, 0, 0, 0, imm, 1, 1, 0);
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] o, input int f3, input int f7,
                       input int z, input int st, input logic [17:0] e);
        vec_t v;
        v.op = o;
        v.f3 = f3[2:0];
        v.f7 = f7[0];
        v.z = z[0];
        v.st = st[3:0];
        v.outs = e;
        tbl.push_back(v);
    endtask

    task automatic r_instr(input int f3, input int f7, input int z,
                           input int alu);
        add(RT, f3, f7, z, 0, f_row(0));
        add(RT, f3, f7, z, 1, d_row(0));
        add(RT, f3, f7, z, 6, pk(0, 0, 0, 0, 0, 2, 0, alu, 0, 0, 0, 0));
        add(RT, f3, f7, z, 7, wb_row(0));
    endtask

    task automatic i_instr(input int f3, input int f7, input int z,
                           input int alu);
        add(IT, f3, f7, z, 0, f_row(0));
        add(IT, f3, f7, z, 1, d_row(0));
        add(IT, f3, f7, z, 8, pk(0, 0, 0, 0, 0, 2, 1, alu, 0, 0, 0, 0));
        add(IT, f3, f7, z, 7, wb_row(0));
    endtask

    task automatic beq_instr(input int z);
        add(BQ, 0, 0, z, 0, f_row(2));
        add(BQ, 0, 0, z, 1, d_row(2));
        add(BQ, 0, 0, z, 10, pk(z, 0, 0, 0, 0, 2, 0, 1, 2, 0, 1, 0));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n_instr;
        exp_t e;
        rst = 1'b1;
        op = 7'd0;
        funct3 = 3'd0;
        funct7b5 = 1'b0;
        zero = 1'b1;

        // lw
        add(LW, 2, 0, 0, 0, f_row(0));
        add(LW, 2, 0, 0, 1, d_row(0));
        add(LW, 2, 0, 0, 2, pk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        add(LW, 2, 0, 0, 3, pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(LW, 2, 0, 0, 4, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        // sw
        add(SW, 2, 0, 1, 0, f_row(1));
        add(SW, 2, 0, 1, 1, d_row(1));
        add(SW, 2, 0, 1, 2, pk(0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
        add(SW, 2, 0, 1, 5, pk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        r_instr(0, 1, 1, 1);
        i_instr(0, 1, 0, 0);
        r_instr(6, 0, 0, 3);
        r_instr(7, 0, 1, 2);
        r_instr(2, 0, 0, 5);
        r_instr(4, 1, 0, 0);
        i_instr(2, 0, 1, 5);
        i_instr(6, 0, 0, 3);
        beq_instr(1);
        beq_instr(0);
        // jal
        add(JL, 0, 0, 1, 0, f_row(3));
        add(JL, 0, 0, 1, 1, d_row(3));
        add(JL, 0, 0, 1, 9, pk(1, 0, 0, 0, 0, 1, 2, 0, 3, 0, 0, 0));
        add(JL, 0, 0, 1, 7, wb_row(3));

        repeat (2) tick();
        @(negedge clk);
        chk("rst_strobes",
            {pc_write, mem_write, ir_write, reg_write, instr_done}, 0);
        chk("rst_instret", instret, 0);
        tick();
        rst = 1'b0;

        n_instr = 0;
        foreach (tbl[i]) begin
            op = tbl[i].op;
            funct3 = tbl[i].f3;
            funct7b5 = tbl[i].f7;
            zero = tbl[i].z;
            e.st = tbl[i].st;
            e.outs = tbl[i].outs;
            e.cnt = n_instr;
            sb.push_back(e);
            if (tbl[i].outs[1]) n_instr++;
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d_state", i), state, e.st);
            chk($sformatf("v%0d_outs", i), act_outs, e.outs);
            chk($sformatf("v%0d_instret", i), instret, e.cnt);
            chk($sformatf("v%0d_nop_state", i), state2, e.st);
            tick();
        end
        chk("table_instret", instret, n_instr);

        // unknown opcode: trap vs. NOP
        op = BAD;
        @(negedge clk);
        chk("bad_fetch", state, 0);
        tick();
        @(negedge clk);
        chk("bad_decode", state, 1);
        chk("bad_done_trap", instr_done, 0);
        chk("bad_done_nop", instr_done2, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_state", k), state, 15);
            chk($sformatf("halt%0d_illegal", k), illegal, 1);
            chk($sformatf("halt%0d_strobes", k),
                {pc_write, mem_write, ir_write, reg_write, instr_done}, 0);
            chk($sformatf("halt%0d_instret", k), instret, n_instr);
            if (k == 0) begin
                chk("nop_back_fetch", state2, 0);
                chk("nop_instret", instret2, n_instr + 1);
            end
            tick();
        end

        rst = 1'b1;
        @(negedge clk);
        chk("halt_rst_strobes",
            {pc_write, mem_write, ir_write, reg_write}, 0);
        tick();
        rst = 1'b0;
        op = LW;
        @(negedge clk);
        chk("post_halt_state", state, 0);
        chk("post_halt_instret", instret, 0);
        chk("post_halt_ir_write", ir_write, 1);

        // abort lw in MEMREAD
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_memread_state", state, 3);
        chk("abort_reg_write", {reg_write, instr_done}, 0);
        tick();
        @(negedge clk);
        chk("abort_next_state", state, 0);
        chk("abort_reg_write2", reg_write, 0);
        chk("abort_instret", instret, 0);
        chk("rst_fetch_strobes", {ir_write, pc_write}, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("lw_after_abort_state", state, 0);
        chk("lw_after_abort_instret", instret, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Main control FSM for the multicycle variant of the RISC-V core. It sequences the shared ALU, the unified instruction/data memory, the instruction register and the register file over several cycles per instruction. It replaces the combinational decoder of the single-cycle cpu, and its strobes (mem_write, reg_write, pc_write) are the signals the cpu testbench monitors. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

Parameters:
TRAP_ILLEGAL, 1, 1 = an unknown opcode enters HALT and stays there; 0 = an unknown opcode is retired as a NOP and the FSM returns to FETCH
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
op  in  7  Instr[6:0] from the instruction register
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
zero  in  1  ALU zero flag
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register and OldPC enable
result_src  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 data
alu_src_b  out  2  ALU B select: 00 rs2 data, 01 ImmExt, 10 constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal  out  1  high while in HALT
state  out  4  current state encoding, for debug and the bench
instret  out  CNT_W  count of retired instructions

Behaviour:
- Registered state, next-state logic and output logic are combinational (Moore outputs, except pc_write, which depends on zero).
- Reset: state = FETCH (0), instret = 0. During rst all strobes are 0. The first FETCH strobes assert on the first cycle after rst deasserts.
- rst asserted in any state, including mid-instruction or HALT, forces FETCH on the next edge. No write strobe may assert while rst is high.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, HALT 15.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE goes by op: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BEQ; 1101111 to JAL; any other op to HALT (TRAP_ILLEGAL=1) or FETCH (TRAP_ILLEGAL=0).
  - MEMADR goes to MEMREAD if op=lw, otherwise to MEMWRITE.
  - MEMREAD to MEMWB; EXECR, EXECI and JAL to ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ go to FETCH.
  - HALT stays in HALT.
- Outputs per state (any signal not listed is 0; alu_control is 000 unless stated):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10, pc_update.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - EXECR and EXECI: alu_src_a=10, alu_src_b=00 (EXECR) or 01 (EXECI), funct decode.
  - ALUWB: result_src=00, reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, branch.
  - HALT: illegal=1, all strobes 0.
- pc_write = pc_update OR (branch AND zero).
- Funct decode:
  - funct3 000: sub if op[5] AND funct7b5, else add. For addi, op[5]=0, so addi is never sub.
  - 010: slt. 110: or. 111: and. Any other funct3: add.
- imm_src is combinational from op in every state: lw and I-type 00, sw 01, beq 10, jal 11, unknown op 00.
- instr_done pulses in MEMWB, MEMWRITE, ALUWB and BEQ. With TRAP_ILLEGAL=0 it also pulses in DECODE for an illegal op.
- instret increments by 1 on each edge where instr_done=1 and rst=0. It wraps modulo 2^CNT_W.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal NOP 2.
- op and funct fields are sampled combinationally. The instruction register only changes in FETCH, so the fields are stable from DECODE onward.

Test Plan:
- Reset then lw (op 0000011): states 0,1,2,3,4,0. ir_write only in state 0. reg_write and result_src=01 in state 4. instret goes 0 to 1.
- sw (0100011): states 0,1,2,5. mem_write=1 for exactly 1 cycle with adr_src=1. imm_src=01. reg_write never asserts.
- R-type sub (funct3 000, funct7b5=1) -> alu_control 001 in EXECR. Same funct3/funct7b5 with addi (0010011) -> 000. funct3 110 -> 011, 111 -> 010, 010 -> 101.
- beq with zero=1 -> pc_write=1 in BEQ, alu_control 001, 3 cycles total. With zero=0 -> pc_write=0 in BEQ.
- jal (1101111): states 0,1,9,7. pc_write=1 in states 0 and 9. reg_write=1 in state 7. imm_src=11.
- op 1111111 with TRAP_ILLEGAL=1 -> HALT(15) and illegal=1 held for 10 cycles. Then rst pulse -> FETCH, instret=0. Also rst asserted in MEMREAD -> FETCH next edge, no reg_write, instret unchanged.
